// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle for the iterative multiply/divide unit.
// master = issuing side (EX stage / bench), slave = mdu_iter.
interface mdu_iter_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      md_ctrl;
    logic [XLEN-1:0] md_sr1;
    logic [XLEN-1:0] md_sr2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] md_res;

    modport master (
        output in_valid, md_ctrl, md_sr1, md_sr2, kill, out_ready,
        input  in_ready, out_valid, md_res
    );

    modport slave (
        input  in_valid, md_ctrl, md_sr1, md_sr2, kill, out_ready,
        output in_ready, out_valid, md_res
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle, one op in flight).
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero, signed divide
// overflow and multiply-by-zero finish at accept instead of iterating.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_iter_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier (shifted out) / quotient (shifted in)
    logic [XLEN-1:0] r_b;       // multiplicand / divisor magnitude
    logic            r_is_div;
    logic            r_is_rem;
    logic            r_upper;
    logic            r_neg;
    logic            r_illegal;
    logic [XLEN-1:0] r_res;

    // Request decode at accept
    logic [7:0]      w_ctrl;
    logic            w_onehot;
    logic            w_is_div_in;
    logic            w_sgn1;
    logic            w_sgn2;
    logic            w_b_zero;
    logic            w_neg_in;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;

    assign w_ctrl      = bus.md_ctrl;
    assign w_onehot    = (w_ctrl != '0) && ((w_ctrl & (w_ctrl - 8'd1)) == '0);
    assign w_is_div_in = |w_ctrl[7:4];
    assign w_sgn1      = bus.md_sr1[XLEN-1] & (w_ctrl[1] | w_ctrl[2] | w_ctrl[4] | w_ctrl[6]);
    assign w_sgn2      = bus.md_sr2[XLEN-1] & (w_ctrl[1] | w_ctrl[4] | w_ctrl[6]);
    assign w_mag1      = w_sgn1 ? -bus.md_sr1 : bus.md_sr1;
    assign w_mag2      = w_sgn2 ? -bus.md_sr2 : bus.md_sr2;
    assign w_b_zero    = (bus.md_sr2 == '0);
    // Divide by zero keeps the all-ones quotient unsigned; remainder follows sr1.
    assign w_neg_in    = w_is_div_in ? (w_ctrl[6] ? w_sgn1 : ((w_sgn1 ^ w_sgn2) & ~w_b_zero))
                                     : (w_sgn1 ^ w_sgn2);

`ifdef MDU_EARLY_OUT_EN
    logic            w_ovf;
    logic            w_mul_zero;
    logic            w_early;
    logic [XLEN-1:0] w_early_res;

    assign w_ovf      = (w_ctrl[4] | w_ctrl[6]) &&
                        (bus.md_sr1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.md_sr2 == '1);
    assign w_mul_zero = !w_is_div_in && ((bus.md_sr1 == '0) || (bus.md_sr2 == '0));
    assign w_early    = w_onehot && ((w_is_div_in && (w_b_zero || w_ovf)) || w_mul_zero);

    // Special-case results, identical to what the iterative path produces
    always_comb begin
        w_early_res = '0;
        if (w_is_div_in) begin
            if (w_b_zero)
                w_early_res = (w_ctrl[4] | w_ctrl[5]) ? '1 : bus.md_sr1;
            else
                w_early_res = w_ctrl[4] ? bus.md_sr1 : '0;
        end
    end
`endif

    // One iteration step and the final sign fix-up
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_qr;
    logic [XLEN-1:0]   w_qr_s;
    logic [XLEN-1:0]   w_final;

    assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[XLEN-1:0] - r_b;
    assign w_prod_s    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_qr        = r_is_rem ? r_hi : r_lo;
    assign w_qr_s      = r_neg ? -w_qr : w_qr;
    assign w_final     = r_illegal ? '0 :
                         r_is_div  ? w_qr_s :
                         r_upper   ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];

    // FSM, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_is_div  <= 1'b0;
            r_is_rem  <= 1'b0;
            r_upper   <= 1'b0;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
            r_res     <= '0;
        end else if (bus.kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_is_div  <= w_is_div_in;
                        r_is_rem  <= w_ctrl[6] | w_ctrl[7];
                        r_upper   <= |w_ctrl[3:1];
                        r_neg     <= w_neg_in;
                        r_illegal <= ~w_onehot;
                        r_hi      <= '0;
                        r_lo      <= w_is_div_in ? w_mag1 : w_mag2;
                        r_b       <= w_is_div_in ? w_mag2 : w_mag1;
                        r_cnt     <= CNT_W'(XLEN);
`ifdef MDU_EARLY_OUT_EN
                        if (w_early) begin
                            r_res   <= w_early_res;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state   <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    // XLEN step cycles, then one cycle for sign fix-up into r_res
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_is_div) begin
                            r_hi <= w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                        end else begin
                            r_hi <= w_mul_sum[XLEN:1];
                            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                        end
                    end else begin
                        r_res   <= w_final;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.md_res    = r_res;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter (XLEN=64 and XLEN=32 instances).
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(64)) if64();
    mdu_iter_if #(.XLEN(32)) if32();

    mdu_iter #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
    mdu_iter #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

`ifdef MDU_EARLY_OUT_EN
    localparam int SPL64 = 1;
    localparam int SPL32 = 1;
`else
    localparam int SPL64 = 65;
    localparam int SPL32 = 33;
`endif
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   seen64 = 1'b0;
    bit   seen32 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h want 0x%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready64(input string nm);
        int n = 0;
        while (!if64.in_ready && n < 300) begin tick(); n++; end
        check({nm, "_ready"}, 64'(if64.in_ready), 64'd1);
    endtask

    // Issue one request and push its expected result/latency once accepted
    task automatic send(input bit w32, input logic [7:0] ctrl, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] res, input int lat,
                        input string nm);
        int   n = 0;
        exp_t e;
        while (!(w32 ? if32.in_ready : if64.in_ready) && n < 300) begin tick(); n++; end
        if (!(w32 ? if32.in_ready : if64.in_ready)) begin
            check({nm, "_accept"}, 64'(w32 ? if32.in_ready : if64.in_ready), 64'd1);
            return;
        end
        if (w32) begin
            if32.in_valid = 1'b1; if32.md_ctrl = ctrl; if32.md_sr1 = a[31:0]; if32.md_sr2 = b[31:0];
        end else begin
            if64.in_valid = 1'b1; if64.md_ctrl = ctrl; if64.md_sr1 = a; if64.md_sr2 = b;
        end
        tick();
        e.res = res; e.lat = lat; e.acc = cyc; e.name = nm;
        if (w32) begin
            if32.in_valid = 1'b0; if32.md_sr1 = ~a[31:0]; if32.md_sr2 = ~b[31:0];
            q32.push_back(e);
        end else begin
            if64.in_valid = 1'b0; if64.md_sr1 = ~a; if64.md_sr2 = ~b;
            q64.push_back(e);
        end
    endtask

    // Monitor for the 64-bit unit
    always @(negedge clk) begin
        if (rst_n && if64.out_valid) begin
            if (q64.size() == 0) begin
                check("spurious_valid64", 64'(if64.out_valid), 64'd0);
            end else begin
                if (!seen64) begin
                    check({q64[0].name, "_lat"}, 64'(cyc - q64[0].acc), 64'(q64[0].lat));
                    seen64 = 1'b1;
                end
                if (if64.out_ready) begin
                    check(q64[0].name, if64.md_res, q64[0].res);
                    void'(q64.pop_front());
                    seen64 = 1'b0;
                end
            end
        end
    end

    // Monitor for the 32-bit unit
    always @(negedge clk) begin
        if (rst_n && if32.out_valid) begin
            if (q32.size() == 0) begin
                check("spurious_valid32", 64'(if32.out_valid), 64'd0);
            end else begin
                if (!seen32) begin
                    check({q32[0].name, "_lat"}, 64'(cyc - q32[0].acc), 64'(q32[0].lat));
                    seen32 = 1'b1;
                end
                if (if32.out_ready) begin
                    check(q32[0].name, {32'h0, if32.md_res}, q32[0].res);
                    void'(q32.pop_front());
                    seen32 = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        if64.in_valid = 1'b0; if64.md_ctrl = '0; if64.md_sr1 = '0; if64.md_sr2 = '0;
        if64.kill = 1'b0; if64.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.md_ctrl = '0; if32.md_sr1 = '0; if32.md_sr2 = '0;
        if32.kill = 1'b0; if32.out_ready = 1'b1;

        repeat (3) tick();
        check("reset_in_ready", 64'(if64.in_ready), 64'd1);
        check("reset_out_valid", 64'(if64.out_valid), 64'd0);
        check("reset_md_res", if64.md_res, 64'd0);
        rst_n = 1'b1;
        tick();

        // Multiply
        send(0, 8'h01, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 65, "mul_3x-5");
        send(0, 8'h08, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max");
        send(0, 8'h04, ONES, 64'd2, ONES, 65, "mulhsu_-1x2");
        send(0, 8'h02, ONES, ONES, 64'd0, 65, "mulh_-1x-1");
        send(0, 8'h02, MIN64, 64'd2, ONES, 65, "mulh_minx2");
        send(0, 8'h01, 64'd0, 64'd123, 64'd0, SPL64, "mul_0x123");
        // Divide
        send(0, 8'h10, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_-7/2");
        send(0, 8'h40, -64'sd7, 64'd2, ONES, 65, "rem_-7/2");
        send(0, 8'h10, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7/-2");
        send(0, 8'h40, 64'd7, -64'sd2, 64'd1, 65, "rem_7/-2");
        send(0, 8'h20, 64'd100, 64'd7, 64'd14, 65, "divu_100/7");
        send(0, 8'h80, 64'd100, 64'd7, 64'd2, 65, "remu_100/7");
        // Corner cases
        send(0, 8'h10, 64'd5, 64'd0, ONES, SPL64, "div_5/0");
        send(0, 8'h40, 64'd5, 64'd0, 64'd5, SPL64, "rem_5/0");
        send(0, 8'h20, 64'd5, 64'd0, ONES, SPL64, "divu_5/0");
        send(0, 8'h80, 64'd5, 64'd0, 64'd5, SPL64, "remu_5/0");
        send(0, 8'h10, MIN64, ONES, MIN64, SPL64, "div_ovf");
        send(0, 8'h40, MIN64, ONES, 64'd0, SPL64, "rem_ovf");
        send(0, 8'h03, 64'd6, 64'd7, 64'd0, 65, "illegal_03");
        send(0, 8'h00, 64'd6, 64'd7, 64'd0, 65, "illegal_00");

        // Backpressure
        wait_ready64("bp");
        if64.out_ready = 1'b0;
        send(0, 8'h20, 64'd100, 64'd7, 64'd14, 65, "bp_divu");
        n = 0;
        while (!if64.out_valid && n < 300) begin tick(); n++; end
        check("bp_valid", 64'(if64.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if64.in_valid = 1'b1; if64.md_ctrl = 8'h01; if64.md_sr1 = 64'd6; if64.md_sr2 = 64'd7;
            tick();
            check("bp_hold_res", if64.md_res, 64'd14);
            check("bp_in_ready", 64'(if64.in_ready), 64'd0);
            check("bp_out_valid", 64'(if64.out_valid), 64'd1);
        end
        if64.in_valid = 1'b0;
        if64.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 64'(if64.in_ready), 64'd1);
        send(0, 8'h01, 64'd6, 64'd7, 64'd42, 65, "bp_next_mul");

        // Kill mid-CALC, then kill coincident with a request in IDLE
        wait_ready64("kill");
        if64.in_valid = 1'b1; if64.md_ctrl = 8'h01;
        if64.md_sr1 = 64'h1234_5678_9ABC_DEF0; if64.md_sr2 = 64'h0FED_CBA9_8765_4321;
        tick();
        if64.in_valid = 1'b0;
        repeat (9) tick();
        if64.kill = 1'b1;
        tick();
        if64.kill = 1'b0;
        check("kill_in_ready", 64'(if64.in_ready), 64'd1);
        check("kill_out_valid", 64'(if64.out_valid), 64'd0);
        repeat (70) tick();
        check("kill_no_valid", 64'(if64.out_valid), 64'd0);
        if64.in_valid = 1'b1; if64.kill = 1'b1; if64.md_ctrl = 8'h01;
        tick();
        if64.in_valid = 1'b0; if64.kill = 1'b0;
        check("kill_blocks_accept", 64'(if64.in_ready), 64'd1);
        send(0, 8'h01, 64'd6, 64'd7, 64'd42, 65, "mul_after_kill");

        // Asynchronous reset mid-CALC
        wait_ready64("rst");
        if64.in_valid = 1'b1; if64.md_ctrl = 8'h08; if64.md_sr1 = ONES; if64.md_sr2 = ONES;
        tick();
        if64.in_valid = 1'b0;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(if64.out_valid), 64'd0);
        check("rst_in_ready", 64'(if64.in_ready), 64'd1);
        check("rst_md_res", if64.md_res, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (70) tick();
        check("rst_no_valid", 64'(if64.out_valid), 64'd0);

        // XLEN=32 instance
        send(1, 8'h10, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33, "div32_-7/2");
        send(1, 8'h01, 64'd3, 64'hFFFF_FFFB, 64'hFFFF_FFF1, 33, "mul32_3x-5");
        send(1, 8'h10, 64'd5, 64'd0, 64'hFFFF_FFFF, SPL32, "div32_5/0");
        send(1, 8'h40, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, SPL32, "rem32_ovf");

        n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 300) begin tick(); n++; end
        check("drain", 64'(q64.size() + q32.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
